// File: rtl/alu_mem_pkg.sv
// Shared opcode and flag definitions for the operand-cache / ALU / data-memory slice.
package alu_mem_pkg;

    localparam logic ALU_ADD  = 1'b0;
    localparam logic ALU_NAND = 1'b1;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;

    typedef enum logic {
        OP_ADD  = ALU_ADD,
        OP_NAND = ALU_NAND
    } alu_op_e;

endpackage

// File: rtl/alu_mem_unit_alu_core.sv
// Combinational ALU: ADD / NAND of the two cached operands plus zero/negative flags.
// Optional carry-out port when ALU_COUT_EN is defined.
module alu_core
    import alu_mem_pkg::*;
#(
    parameter int WORD_RANGE  = 8,
    parameter int FLAGS_COUNT = 2
) (
    input  logic                   alu_op,
    input  logic [WORD_RANGE-1:0]  op_a,
    input  logic [WORD_RANGE-1:0]  op_b,
    output logic [WORD_RANGE-1:0]  result,
    output logic [FLAGS_COUNT-1:0] flags
`ifdef ALU_COUT_EN
    ,
    output logic                   cout
`endif
);

`ifdef ALU_COUT_EN
    logic [WORD_RANGE:0] w_sum;
    assign w_sum = {1'b0, op_a} + {1'b0, op_b};
`else
    logic [WORD_RANGE-1:0] w_sum;
    assign w_sum = op_a + op_b;
`endif

    always_comb begin
        result = '0;
`ifdef ALU_COUT_EN
        cout   = 1'b0;
`endif
        case (alu_op_e'(alu_op))
            OP_ADD: begin
                result = w_sum[WORD_RANGE-1:0];
`ifdef ALU_COUT_EN
                cout   = w_sum[WORD_RANGE];
`endif
            end
            OP_NAND: result = ~(op_a & op_b);
            default: result = '0;
        endcase
    end

    always_comb begin
        flags            = '0;
        flags[FLAG_ZERO] = (result == '0);
        flags[FLAG_NEG]  = result[WORD_RANGE-1];
    end

endmodule

// File: rtl/alu_mem_unit.sv
// Operand caches A/B, address mux and data memory around alu_core.
// Build option: define ALU_COUT_EN to expose the ADD carry-out on port cout.
module alu_mem_unit
    import alu_mem_pkg::*;
#(
    parameter int WORD_RANGE        = 8,
    parameter int MEMORY_WORD_COUNT = 256,
    parameter int FLAGS_COUNT       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_RANGE-1:0]  data_in,
    input  logic                   load_operand,
    input  logic                   cache_a_b_not,
    input  logic                   is_data_indirect,
    input  logic                   alu_op,
    input  logic                   write_mem_result,
    input  logic [WORD_RANGE-1:0]  write_address,
    output logic [WORD_RANGE-1:0]  alu_out,
    output logic [FLAGS_COUNT-1:0] flags
`ifdef ALU_COUT_EN
    ,
    output logic                   cout
`endif
);

    logic [WORD_RANGE-1:0] r_a;
    logic [WORD_RANGE-1:0] r_b;
    logic [WORD_RANGE-1:0] r_mem [0:MEMORY_WORD_COUNT-1];

    logic [WORD_RANGE-1:0] w_mem_addr;
    logic [WORD_RANGE-1:0] w_mem_rdata;
    logic [WORD_RANGE-1:0] w_load_val;
    logic                  w_rd_ok;
    logic                  w_wr_ok;

    // Write-back owns the address port whenever it is strobed.
    assign w_mem_addr = write_mem_result ? write_address : data_in;

    generate
        if (MEMORY_WORD_COUNT < (1 << WORD_RANGE)) begin : g_partial_map
            assign w_rd_ok = (32'(w_mem_addr)    < MEMORY_WORD_COUNT);
            assign w_wr_ok = (32'(write_address) < MEMORY_WORD_COUNT);
        end else begin : g_full_map
            assign w_rd_ok = 1'b1;
            assign w_wr_ok = 1'b1;
        end
    endgenerate

    assign w_mem_rdata = w_rd_ok ? r_mem[w_mem_addr] : '0;
    assign w_load_val  = is_data_indirect ? w_mem_rdata : data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (load_operand) begin
            if (cache_a_b_not) begin
                r_a <= w_load_val;
            end else begin
                r_b <= w_load_val;
            end
        end
    end

    // Memory contents survive reset; reset only blocks the write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (write_mem_result && w_wr_ok) begin
            r_mem[write_address] <= alu_out;
        end
    end

    alu_core #(
        .WORD_RANGE  (WORD_RANGE),
        .FLAGS_COUNT (FLAGS_COUNT)
    ) u_alu_core (
        .alu_op (alu_op),
        .op_a   (r_a),
        .op_b   (r_b),
        .result (alu_out),
        .flags  (flags)
`ifdef ALU_COUT_EN
        ,
        .cout   (cout)
`endif
    );

endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed, table-driven bench for alu_mem_unit (plus hand sequences for memory and reset corners).
module tb_alu_mem_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load_operand;
    logic       cache_a_b_not;
    logic       is_data_indirect;
    logic       alu_op;
    logic       write_mem_result;
    logic [7:0] write_address;
    logic [7:0] alu_out;
    logic [1:0] flags;
`ifdef ALU_COUT_EN
    logic       cout;
`endif

    int n_cmp;
    int n_err;

    alu_mem_unit #(
        .WORD_RANGE        (8),
        .MEMORY_WORD_COUNT (256),
        .FLAGS_COUNT       (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in          (data_in),
        .load_operand     (load_operand),
        .cache_a_b_not    (cache_a_b_not),
        .is_data_indirect (is_data_indirect),
        .alu_op           (alu_op),
        .write_mem_result (write_mem_result),
        .write_address    (write_address),
        .alu_out          (alu_out),
        .flags            (flags)
`ifdef ALU_COUT_EN
        ,
        .cout             (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] exp_out;
        logic [1:0] exp_flags;
        logic       exp_cout;
        string      name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", nm, got, exp);
        end
    endtask

    task automatic do_load(input logic to_a, input logic ind, input logic [7:0] val);
        @(negedge clk);
        load_operand     = 1'b1;
        cache_a_b_not    = to_a;
        is_data_indirect = ind;
        data_in          = val;
        @(posedge clk);
        #1;
        load_operand     = 1'b0;
        is_data_indirect = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr);
        @(negedge clk);
        write_mem_result = 1'b1;
        write_address    = addr;
        @(posedge clk);
        #1;
        write_mem_result = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 2'b00, 1'b0, "add_basic"};
        vecs[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 2'b01, 1'b1, "add_ovf_zero"};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 2'b10, 1'b0, "add_to_neg"};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 2'b01, 1'b0, "nand_ones"};
        vecs[4] = '{8'hF0, 8'h0F, 1'b1, 8'hFF, 2'b10, 1'b0, "nand_disjoint"};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 2'b10, 1'b0, "nand_zeros"};
        vecs[6] = '{8'h3C, 8'hC4, 1'b0, 8'h00, 2'b01, 1'b1, "add_wrap_zero"};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 2'b00, 1'b0, "add_plain"};
        vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'hFF, 2'b10, 1'b0, "nand_alt"};
        vecs[9] = '{8'hFF, 8'h01, 1'b0, 8'h00, 2'b01, 1'b1, "add_ff_plus1"};

        rst_n            = 1'b0;
        data_in          = 8'h00;
        load_operand     = 1'b0;
        cache_a_b_not    = 1'b0;
        is_data_indirect = 1'b0;
        alu_op           = 1'b0;
        write_mem_result = 1'b0;
        write_address    = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", alu_out, 8'h00);
        chk("reset_flags", {6'b0, flags}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_load(1'b1, 1'b0, vecs[i].a);
            do_load(1'b0, 1'b0, vecs[i].b);
            alu_op = vecs[i].op;
            @(negedge clk);
            chk({vecs[i].name, "_out"}, alu_out, vecs[i].exp_out);
            chk({vecs[i].name, "_flags"}, {6'b0, flags}, {6'b0, vecs[i].exp_flags});
`ifdef ALU_COUT_EN
            chk({vecs[i].name, "_cout"}, {7'b0, cout}, {7'b0, vecs[i].exp_cout});
`endif
        end

        // write-back then indirect load
        alu_op = 1'b0;
        do_load(1'b1, 1'b0, 8'h05);
        do_load(1'b0, 1'b0, 8'h03);
        do_write(8'h10);
        do_load(1'b1, 1'b0, 8'h00);
        do_load(1'b0, 1'b1, 8'h10);
        @(negedge clk);
        chk("indirect_load", alu_out, 8'h08);

        // simultaneous write and indirect load: read-before-write
        do_load(1'b1, 1'b0, 8'h11);
        do_load(1'b0, 1'b0, 8'h00);
        do_write(8'h20);
        do_load(1'b1, 1'b0, 8'h01);
        do_load(1'b0, 1'b0, 8'h21);
        @(negedge clk);
        chk("pre_simul_out", alu_out, 8'h22);
        write_mem_result = 1'b1;
        write_address    = 8'h20;
        load_operand     = 1'b1;
        cache_a_b_not    = 1'b1;
        is_data_indirect = 1'b1;
        data_in          = 8'h99;
        @(posedge clk);
        #1;
        write_mem_result = 1'b0;
        load_operand     = 1'b0;
        is_data_indirect = 1'b0;
        @(negedge clk);
        chk("simul_old_data", alu_out, 8'h32);
        do_load(1'b1, 1'b0, 8'h00);
        do_load(1'b0, 1'b1, 8'h20);
        @(negedge clk);
        chk("simul_new_data", alu_out, 8'h22);

        // async reset mid-cycle blocks a same-edge load and write
        do_load(1'b1, 1'b0, 8'h07);
        do_load(1'b0, 1'b0, 8'h00);
        do_write(8'h30);
        do_load(1'b0, 1'b0, 8'h01);
        @(negedge clk);
        chk("pre_reset_out", alu_out, 8'h08);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", alu_out, 8'h00);
        chk("async_reset_flags", {6'b0, flags}, 8'h01);
        @(negedge clk);
        load_operand     = 1'b1;
        cache_a_b_not    = 1'b1;
        data_in          = 8'h44;
        write_mem_result = 1'b1;
        write_address    = 8'h30;
        @(posedge clk);
        #1;
        chk("reset_blocks_load", alu_out, 8'h00);
        @(negedge clk);
        load_operand     = 1'b0;
        write_mem_result = 1'b0;
        rst_n            = 1'b1;
        do_load(1'b1, 1'b0, 8'h00);
        do_load(1'b0, 1'b1, 8'h30);
        @(negedge clk);
        chk("reset_blocks_write", alu_out, 8'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
